// File: rtl/av2_recon_pkg.sv
// Shared constants and entry layout for the AV2 reconstruction pixel stream.
package av2_recon_pkg;

   localparam int unsigned XY_W          = 16;
   localparam int unsigned BIT_DEPTH_DEF = 10;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   // Largest code value for a given pixel depth.
   function automatic int unsigned pix_max(input int unsigned bd);
      return (32'd1 << bd) - 32'd1;
   endfunction

   localparam int unsigned PIX_MAX = (32'd1 << BIT_DEPTH_DEF) - 32'd1;

   // Output entry at the default depth; field order is the packing order on the FIFO.
   typedef struct packed {
      logic [BIT_DEPTH_DEF-1:0] pixel;
      logic [XY_W-1:0]          x;
      logic [XY_W-1:0]          y;
      logic                     sof;
      logic                     eol;
      logic                     eof;
   } recon_entry_t;

   function automatic int unsigned entry_w(input int unsigned bd);
      return bd + 2 * XY_W + 3;
   endfunction

endpackage

// File: rtl/av2_skid_fifo2.sv
// Two-entry first-word-fall-through FIFO; head entry is always held in dout.
module av2_skid_fifo2 #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic [1:0]   count,
   output logic         valid
);

   logic [W-1:0] tail;

   // Pop on empty and push on full are ignored.
   always_ff @(posedge clk) begin
      if (rst) begin
         dout  <= '0;
         tail  <= '0;
         count <= 2'd0;
         valid <= 1'b0;
      end else begin
         case (count)
            2'd0: begin
               if (push) begin
                  dout  <= din;
                  count <= 2'd1;
                  valid <= 1'b1;
               end
            end
            2'd1: begin
               if (push && pop) begin
                  dout <= din;
               end else if (push) begin
                  tail  <= din;
                  count <= 2'd2;
               end else if (pop) begin
                  count <= 2'd0;
                  valid <= 1'b0;
               end
            end
            default: begin
               if (pop) begin
                  dout <= tail;
                  if (push) tail <= din;
                  else      count <= 2'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: rtl/av2_recon_pixel_stream.sv
// Adds prediction and residual, clips to pixel depth and streams positioned pixels to deblocking.
module av2_recon_pixel_stream
   import av2_recon_pkg::*;
#(
   parameter int unsigned BIT_DEPTH  = 10,
   parameter int unsigned RES_W      = 16,
   parameter int unsigned MAX_WIDTH  = 128,
   parameter int unsigned MAX_HEIGHT = 128
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [15:0]          frame_width,
   input  logic [15:0]          frame_height,
   input  logic                 start,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [BIT_DEPTH-1:0] in_pred,
   input  logic [RES_W-1:0]     in_resid,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [BIT_DEPTH-1:0] out_pixel,
   output logic [15:0]          out_x,
   output logic [15:0]          out_y,
   output logic                 out_sof,
   output logic                 out_eol,
   output logic                 out_eof,
   output logic                 busy,
   output logic                 done,
   output logic                 err_size
);

   localparam int unsigned SUM_W = ((BIT_DEPTH > RES_W) ? BIT_DEPTH : RES_W) + 2;
   localparam int unsigned ENT_W = entry_w(BIT_DEPTH);
   localparam logic [SUM_W-1:0] PIX_MAX_S = SUM_W'(pix_max(BIT_DEPTH));

   typedef struct packed {
      logic [BIT_DEPTH-1:0] pixel;
      logic [XY_W-1:0]      x;
      logic [XY_W-1:0]      y;
      logic                 sof;
      logic                 eol;
      logic                 eof;
   } entry_t;

   logic [1:0]      state, state_nxt;
   logic [XY_W-1:0] width_q, width_nxt, height_q, height_nxt;
   logic [XY_W-1:0] x_q, x_nxt, y_q, y_nxt;
   logic            err_nxt, done_nxt, busy_nxt, in_ready_nxt;
   logic            accept, pop, size_bad, eol_c, eof_c;
   logic [1:0]      fifo_count, cnt_nxt;
   logic [SUM_W-1:0] sum;
   logic [BIT_DEPTH-1:0] pixel;
   entry_t          push_ent, head_ent;
   logic            fifo_valid;

   assign accept = in_valid && in_ready;
   assign pop    = fifo_valid && out_ready;
   assign eol_c  = (x_q == width_q - XY_W'(1));
   assign eof_c  = eol_c && (y_q == height_q - XY_W'(1));

   assign size_bad = (frame_width == '0) || (frame_height == '0) ||
                     (frame_width > XY_W'(MAX_WIDTH)) || (frame_height > XY_W'(MAX_HEIGHT));

   // Clip adder: zero-extended prediction plus sign-extended residual.
   always_comb begin
      sum = {{(SUM_W-BIT_DEPTH){1'b0}}, in_pred} +
            {{(SUM_W-RES_W){in_resid[RES_W-1]}}, in_resid};
      if (sum[SUM_W-1])          pixel = '0;
      else if (sum > PIX_MAX_S)  pixel = '1;
      else                       pixel = sum[BIT_DEPTH-1:0];
   end

   always_comb begin
      push_ent.pixel = pixel;
      push_ent.x     = x_q;
      push_ent.y     = y_q;
      push_ent.sof   = (x_q == '0) && (y_q == '0);
      push_ent.eol   = eol_c;
      push_ent.eof   = eof_c;
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_nxt  = state;
      width_nxt  = width_q;
      height_nxt = height_q;
      x_nxt      = x_q;
      y_nxt      = y_q;
      err_nxt    = 1'b0;
      cnt_nxt    = fifo_count + 2'(accept) - 2'(pop);
      case (state)
         ST_IDLE: begin
            if (start) begin
               width_nxt  = frame_width;
               height_nxt = frame_height;
               if (size_bad) begin
                  err_nxt = 1'b1;
               end else begin
                  state_nxt = ST_RUN;
                  x_nxt     = '0;
                  y_nxt     = '0;
               end
            end
         end
         ST_RUN: begin
            if (accept) begin
               if (eol_c) begin
                  x_nxt = '0;
                  y_nxt = y_q + XY_W'(1);
                  if (eof_c) state_nxt = ST_DRAIN;
               end else begin
                  x_nxt = x_q + XY_W'(1);
               end
            end
         end
         ST_DRAIN: if (cnt_nxt == 2'd0) state_nxt = ST_DONE;
         default:  state_nxt = ST_IDLE;
      endcase
      in_ready_nxt = (state_nxt == ST_RUN) && (cnt_nxt != 2'd2);
      busy_nxt     = (state_nxt == ST_RUN) || (state_nxt == ST_DRAIN);
      done_nxt     = (state_nxt == ST_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         width_q  <= '0;
         height_q <= '0;
         x_q      <= '0;
         y_q      <= '0;
         in_ready <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err_size <= 1'b0;
      end else begin
         state    <= state_nxt;
         width_q  <= width_nxt;
         height_q <= height_nxt;
         x_q      <= x_nxt;
         y_q      <= y_nxt;
         in_ready <= in_ready_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
         err_size <= err_nxt;
      end
   end

   av2_skid_fifo2 #(.W(ENT_W)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (accept),
      .pop   (pop),
      .din   (push_ent),
      .dout  (head_ent),
      .count (fifo_count),
      .valid (fifo_valid)
   );

   assign out_valid = fifo_valid;
   assign out_pixel = head_ent.pixel;
   assign out_x     = head_ent.x;
   assign out_y     = head_ent.y;
   assign out_sof   = head_ent.sof;
   assign out_eol   = head_ent.eol;
   assign out_eof   = head_ent.eof;

endmodule

// File: tb/tb_av2_recon_pixel_stream.sv
// Directed and randomised-handshake bench for av2_recon_pixel_stream.
module tb_av2_recon_pixel_stream;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] frame_width = '0, frame_height = '0;
   logic        start = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic [9:0]  in_pred = '0;
   logic [15:0] in_resid = '0;
   logic        in_ready, out_valid, out_sof, out_eol, out_eof, busy, done, err_size;
   logic [9:0]  out_pixel;
   logic [15:0] out_x, out_y;

   int n_checks = 0, n_errors = 0;
   int cyc = 0, col_n = 0, done_cnt = 0, hold_bad = 0;
   int first_acc_cyc = 0;
   int rand_mode = 0;
   int pred_a[16384];
   int resid_a[16384];
   logic [63:0] col_v[20000];
   int col_c[20000];
   logic [63:0] prev_vec = '0;
   logic        stall_prev = 1'b0;

   int dir_resid[8] = '{0, 5, -100, -101, 2000, -2000, 1, -1};
   int dir_pix[8]   = '{100, 105, 0, 0, 1023, 0, 101, 99};
   int dir_mark[8]  = '{4, 0, 0, 2, 0, 0, 0, 3};

   av2_recon_pixel_stream dut (
      .clk(clk), .rst(rst), .frame_width(frame_width), .frame_height(frame_height),
      .start(start), .in_valid(in_valid), .in_ready(in_ready), .in_pred(in_pred),
      .in_resid(in_resid), .out_valid(out_valid), .out_ready(out_ready),
      .out_pixel(out_pixel), .out_x(out_x), .out_y(out_y), .out_sof(out_sof),
      .out_eol(out_eol), .out_eof(out_eof), .busy(busy), .done(done), .err_size(err_size)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Output collector and done counter, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst) begin
         if (out_valid && out_ready && col_n < 20000) begin
            col_v[col_n] <= 64'({out_pixel, out_x, out_y, out_sof, out_eol, out_eof});
            col_c[col_n] <= cyc;
            col_n <= col_n + 1;
         end
         if (done) done_cnt <= done_cnt + 1;
      end
   end

   // A stalled beat must reappear unchanged on the next cycle.
   always @(negedge clk) begin
      if (rst) begin
         stall_prev <= 1'b0;
      end else begin
         if (stall_prev && prev_vec != 64'({out_valid, out_pixel, out_x, out_y, out_sof, out_eol, out_eof}))
            hold_bad <= hold_bad + 1;
         stall_prev <= out_valid && !out_ready;
         prev_vec   <= 64'({out_valid, out_pixel, out_x, out_y, out_sof, out_eol, out_eof});
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic int clip(input int p, input int r);
      int s = p + r;
      if (s < 0) return 0;
      if (s > 1023) return 1023;
      return s;
   endfunction

   function automatic logic [63:0] exp_vec(input int pix, input int x, input int y,
                                           input int w, input int h);
      logic sof, eol, eof;
      sof = (x == 0) && (y == 0);
      eol = (x == w - 1);
      eof = eol && (y == h - 1);
      return 64'({10'(pix), 16'(x), 16'(y), sof, eol, eof});
   endfunction

   task automatic do_start(input int w, input int h);
      frame_width  = 16'(w);
      frame_height = 16'(h);
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic send_beats(input int first, input int last, input int budget,
                             output int next, output int used);
      int  i = first;
      int  n = 0;
      logic acc;
      while (i <= last && n < budget) begin
         if (rand_mode != 0) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
         end else begin
            in_valid = 1'b1;
         end
         in_pred  = 10'(pred_a[i]);
         in_resid = 16'(resid_a[i]);
         @(negedge clk);
         acc = in_valid && in_ready;
         if (acc && i == first) first_acc_cyc = cyc;
         step();
         if (acc) i++;
         n++;
      end
      in_valid = 1'b0;
      next = i;
      used = n;
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      while (!done && n < budget) begin
         step();
         n++;
      end
      check("done_seen", 64'(done), 64'd1);
      step();
   endtask

   task automatic load_dir();
      for (int i = 0; i < 8; i++) begin
         pred_a[i]  = 100;
         resid_a[i] = dir_resid[i];
      end
   endtask

   task automatic check_dir(input string tag, input int base);
      check({tag, "_count"}, 64'(col_n - base), 64'd8);
      for (int i = 0; i < 8; i++) begin
         check({tag, "_pix"},  64'(col_v[base+i][44:35]), 64'(dir_pix[i]));
         check({tag, "_xy"},   64'(col_v[base+i][34:3]), 64'({16'(i % 4), 16'(i / 4)}));
         check({tag, "_mark"}, 64'(col_v[base+i][2:0]), 64'(dir_mark[i]));
      end
   endtask

   initial begin
      int base, dbase, nx, used;

      // Reset state.
      repeat (2) step();
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_busy_done_err", 64'({busy, done, err_size}), 64'd0);
      check("rst_out_data", 64'({out_pixel, out_x, out_y, out_sof, out_eol, out_eof}), 64'd0);
      rst = 1'b0;
      step();

      // 4x2 frame, downstream always ready.
      load_dir();
      base = col_n; dbase = done_cnt;
      do_start(4, 2);
      check("d_busy", 64'(busy), 64'd1);
      send_beats(0, 7, 50, nx, used);
      check("d_sent", 64'(nx), 64'd8);
      check("d_cycles", 64'(used), 64'd8);
      wait_done(20);
      repeat (3) step();
      check_dir("d", base);
      check("d_latency", 64'(col_c[base] - first_acc_cyc), 64'd1);
      check("d_done_once", 64'(done_cnt - dbase), 64'd1);
      check("d_idle_busy", 64'(busy), 64'd0);

      // Same frame with downstream stalled.
      base = col_n; dbase = done_cnt;
      do_start(4, 2);
      out_ready = 1'b0;
      send_beats(0, 7, 6, nx, used);
      check("s_accepted", 64'(nx), 64'd2);
      check("s_in_ready", 64'(in_ready), 64'd0);
      check("s_head", 64'({out_valid, out_pixel, out_x, out_y, out_sof}),
            64'({1'b1, 10'd100, 16'd0, 16'd0, 1'b1}));
      check("s_hold", 64'(hold_bad), 64'd0);
      out_ready = 1'b1;
      send_beats(nx, 7, 50, nx, used);
      check("s_sent", 64'(nx), 64'd8);
      wait_done(20);
      repeat (2) step();
      check_dir("s", base);
      check("s_done_once", 64'(done_cnt - dbase), 64'd1);

      // Rejected frame sizes.
      do_start(0, 2);
      check("e0_pulse", 64'({err_size, busy, in_ready}), 64'b100);
      step();
      check("e0_after", 64'({err_size, busy, in_ready}), 64'b000);
      do_start(4, 129);
      check("e1_pulse", 64'({err_size, busy, in_ready}), 64'b100);
      step();
      check("e1_after", 64'({err_size, busy, in_ready}), 64'b000);

      // 1x1 frame saturating high.
      pred_a[0] = 1023; resid_a[0] = 1;
      base = col_n;
      do_start(1, 1);
      send_beats(0, 0, 20, nx, used);
      wait_done(20);
      check("one_count", 64'(col_n - base), 64'd1);
      check("one_beat", col_v[base], exp_vec(1023, 0, 0, 1, 1));

      // Reset in mid-frame, then restart.
      load_dir();
      do_start(4, 2);
      out_ready = 1'b0;
      send_beats(0, 2, 20, nx, used);
      rst = 1'b1;
      step();
      check("mr_state", 64'({busy, out_valid, in_ready}), 64'd0);
      rst = 1'b0;
      out_ready = 1'b1;
      step();
      base = col_n;
      do_start(4, 2);
      send_beats(0, 7, 50, nx, used);
      wait_done(20);
      check_dir("mr", base);

      // 128x128 with random handshakes.
      for (int i = 0; i < 16384; i++) begin
         pred_a[i]  = int'($urandom_range(0, 1023));
         resid_a[i] = int'($urandom_range(0, 4095)) - 2048;
      end
      resid_a[0] = -32768;
      resid_a[1] = 32767;
      base = col_n; dbase = done_cnt;
      rand_mode = 1;
      do_start(128, 128);
      send_beats(0, 16383, 80000, nx, used);
      rand_mode = 0;
      out_ready = 1'b1;
      check("r_sent", 64'(nx), 64'd16384);
      wait_done(20);
      repeat (2) step();
      check("r_count", 64'(col_n - base), 64'd16384);
      for (int i = 0; i < 16384; i++)
         check("r_beat", col_v[base+i],
               exp_vec(clip(pred_a[i], resid_a[i]), i % 128, i / 128, 128, 128));
      check("r_done_once", 64'(done_cnt - dbase), 64'd1);
      check("r_hold", 64'(hold_bad), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation exceeded its time limit");
      $fatal(1);
   end

endmodule
